// File: rtl/audio_pkg.sv
// Shared audio serial-interface definitions, used by the receive and transmit shifters.
package audio_pkg;
  localparam int AUDIO_DATA_W    = 16;
  localparam int AUDIO_SLOT_BCLK = 32;
  localparam int AUDIO_MSB_POS   = 1;
  localparam int AUDIO_LSB_POS   = AUDIO_MSB_POS + AUDIO_DATA_W - 1;
  localparam int POS_W           = $clog2(AUDIO_SLOT_BCLK);

  typedef enum logic {ST_IDLE, ST_RUN} aud_state_e;

  // One in-flight capture: which slot it belongs to and whether it is the LSB.
  typedef struct packed {
    logic vld;
    logic right;
    logic last;
  } cap_t;

  function automatic logic in_word(input logic [POS_W-1:0] pos);
    return (pos >= POS_W'(AUDIO_MSB_POS)) && (pos <= POS_W'(AUDIO_LSB_POS));
  endfunction
endpackage

// File: rtl/audio_bclk_gen.sv
// Bit/frame clock generator: half-period counter, 64-bclk frame counter, edge strobes.
module audio_bclk_gen
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             aud_bclk,
  output logic             aud_adclrck,
  output logic             rise,
  output logic             fall,
  output logic [POS_W-1:0] slot_pos,
  output logic             slot_right
);
  localparam int HC_W = $clog2(BCLK_HALF);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(BCLK_HALF - 1);

  logic [HC_W-1:0]  hc;
  logic [POS_W:0]   bc;
  logic [POS_W:0]   bc_nxt;

  assign bc_nxt     = bc + (POS_W + 1)'(1);
  assign slot_pos   = bc[POS_W-1:0];
  assign slot_right = bc[POS_W];

  always_ff @(posedge clk) begin
    rise <= 1'b0;
    fall <= 1'b0;
    if (reset || !run) begin
      hc          <= '0;
      bc          <= '0;
      aud_bclk    <= 1'b0;
      aud_adclrck <= 1'b0;
    end else if (hc == HC_MAX) begin
      hc       <= '0;
      aud_bclk <= ~aud_bclk;
      if (aud_bclk) begin
        // frame clock follows bc so it only moves on the falling edge
        bc          <= bc_nxt;
        aud_adclrck <= bc_nxt[POS_W];
        fall        <= 1'b1;
      end else begin
        rise <= 1'b1;
      end
    end else begin
      hc <= hc + HC_W'(1);
    end
  end
endmodule

// File: rtl/audio_deshifter.sv
// I2S receive shifter: drives bclk/lrck to the codec and deserialises left/right samples.
module audio_deshifter
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    aud_adcdat,
  output logic                    aud_bclk,
  output logic                    aud_adclrck,
  output logic [AUDIO_DATA_W-1:0] ldata,
  output logic [AUDIO_DATA_W-1:0] rdata,
  output logic                    valid
);
  aud_state_e              state;
  logic                    run;
  logic                    bclk_rise;
  logic                    bclk_fall;
  logic [POS_W-1:0]        slot_pos;
  logic                    slot_right;
  logic [1:0]              sync;
  logic [AUDIO_DATA_W-1:0] shreg;
  logic [AUDIO_DATA_W-1:0] shadow;
  logic [AUDIO_DATA_W-1:0] word;
  cap_t                    cap_now;
  cap_t                    cap_q;

  assign run = (state == ST_RUN) && enable;

  audio_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk_gen (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .aud_bclk   (aud_bclk),
    .aud_adclrck(aud_adclrck),
    .rise       (bclk_rise),
    .fall       (bclk_fall),
    .slot_pos   (slot_pos),
    .slot_right (slot_right)
  );

  assign cap_now.vld   = bclk_rise && in_word(slot_pos);
  assign cap_now.right = slot_right;
  assign cap_now.last  = (slot_pos == POS_W'(AUDIO_LSB_POS));
  assign word          = {shreg[AUDIO_DATA_W-2:0], sync[1]};

  // Capture lands 2 clk after the rising strobe: rise -> cap_q -> shift,
  // which lines up with the synchronised copy of the bit sampled at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      sync   <= '0;
      cap_q  <= '0;
      shreg  <= '0;
      shadow <= '0;
      ldata  <= '0;
      rdata  <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      sync  <= {sync[0], aud_adcdat};
      state <= enable ? ST_RUN : ST_IDLE;
      if (!enable) begin
        cap_q  <= '0;
        shreg  <= '0;
        shadow <= '0;
      end else begin
        // a capture never spans a falling edge (BCLK_HALF >= 3), so flush there
        cap_q <= bclk_fall ? '0 : cap_now;
        if (cap_q.vld) begin
          shreg <= word;
          if (cap_q.last && !cap_q.right) shadow <= word;
          if (cap_q.last && cap_q.right) begin
            ldata <= shadow;
            rdata <= word;
            valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_deshifter.sv
// Bench: I2S codec models feeding two deshifters (BCLK_HALF 4 directed, 3 random stream).
module tb_audio_deshifter;
  localparam int H0 = 4;
  localparam int H1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a [2];
  logic        en_a  [2];
  logic        adc_a [2];
  logic        bclk_a[2];
  logic        lrck_a[2];
  logic        vld_a [2];
  logic [15:0] ld_a  [2];
  logic [15:0] rd_a  [2];

  audio_deshifter #(.BCLK_HALF(H0)) u_dut4 (
    .clk(clk), .reset(rst_a[0]), .enable(en_a[0]), .aud_adcdat(adc_a[0]),
    .aud_bclk(bclk_a[0]), .aud_adclrck(lrck_a[0]), .ldata(ld_a[0]), .rdata(rd_a[0]),
    .valid(vld_a[0]));

  audio_deshifter #(.BCLK_HALF(H1)) u_dut3 (
    .clk(clk), .reset(rst_a[1]), .enable(en_a[1]), .aud_adcdat(adc_a[1]),
    .aud_bclk(bclk_a[1]), .aud_adclrck(lrck_a[1]), .ldata(ld_a[1]), .rdata(rd_a[1]),
    .valid(vld_a[1]));

  int          n_checks = 0;
  int          n_errors = 0;
  int          nval[2];
  logic [32:0] txq0[$], txq1[$];   // {pad, left, right} per frame
  logic [31:0] expq0[$], expq1[$]; // {left, right} expected at valid

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Codec: advances its slot counter on each bclk fall and drives the new bit right after it.
  task automatic codec(input int k);
    int cnt = 0;
    int p;
    int idx = 0;
    logic [32:0] cur = '0;
    logic prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_a[k] || !en_a[k]) begin
        cnt = 0;
        adc_a[k] = cur[32];
      end else if (prev && !bclk_a[k]) begin
        cnt = (cnt + 1) % 64;
        p = cnt % 32;
        if (cnt == 1) begin
          if (k == 0) cur = (idx < txq0.size()) ? txq0[idx] : 33'd0;
          else        cur = (idx < txq1.size()) ? txq1[idx] : 33'd0;
          if ((k == 0 && idx < txq0.size()) || (k == 1 && idx < txq1.size())) idx++;
        end
        if (p >= 1 && p <= 16) adc_a[k] = (cnt < 32) ? cur[32-p] : cur[16-p];
        else                   adc_a[k] = cur[32];
        if (cnt == 48) begin
          if (k == 0) expq0.push_back(cur[31:0]);
          else        expq1.push_back(cur[31:0]);
        end
      end
      prev = bclk_a[k];
    end
  endtask

  task automatic sb(input int k);
    int cyc = 0;
    int last = -1;
    int per;
    logic [31:0] e;
    bit have;
    per = 128 * ((k == 0) ? H0 : H1);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_a[k] || !en_a[k]) last = -1;
      if (vld_a[k] === 1'b1) begin
        nval[k]++;
        have = (k == 0) ? (expq0.size() > 0) : (expq1.size() > 0);
        chk("sb_expected_frame", 32'(have), 32'd1);
        if (have) begin
          e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
          chk("sb_ldata", 32'(ld_a[k]), 32'(e[31:16]));
          chk("sb_rdata", 32'(rd_a[k]), 32'(e[15:0]));
        end
        if (last >= 0) chk("sb_valid_period", cyc - last, per);
        last = cyc;
      end
    end
  endtask

  function automatic logic sig0(input int sel);
    return (sel == 0) ? bclk_a[0] : lrck_a[0];
  endfunction

  task automatic wait_edge(input int sel, input bit rising, input int count, input int maxc,
                           output int n);
    logic prev, cur;
    int seen = 0;
    bit to = 1'b1;
    prev = sig0(sel);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      cur = sig0(sel);
      if (cur !== prev && cur === rising) seen++;
      prev = cur;
      if (seen == count) begin n = i; to = 1'b0; break; end
    end
    chk("edge_timeout", 32'(to), 32'd0);
  endtask

  task automatic wait_valid(input int k, input int maxc, output int n);
    bit to = 1'b1;
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (vld_a[k] === 1'b1) begin n = i; to = 1'b0; break; end
    end
    chk("valid_timeout", 32'(to), 32'd0);
  endtask

  task automatic wait_nval(input int k, input int target, input int maxc);
    bit to = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (nval[k] >= target) begin to = 1'b0; break; end
    end
    chk("nval_timeout", 32'(to), 32'd0);
  endtask

  initial begin
    int n;
    int nv;
    localparam int LAT0 = 97 * H0 + 3;
    rst_a[0] = 1'b1; rst_a[1] = 1'b1;
    en_a[0]  = 1'b0; en_a[1]  = 1'b0;
    adc_a[0] = 1'b0; adc_a[1] = 1'b0;
    nval[0] = 0; nval[1] = 0;
    fork
      codec(0);
      codec(1);
      sb(0);
      sb(1);
    join_none
    repeat (4) @(negedge clk);
    chk("reset_bclk",  32'(bclk_a[0]), 32'd0);
    chk("reset_lrck",  32'(lrck_a[0]), 32'd0);
    chk("reset_ldata", 32'(ld_a[0]),   32'd0);
    chk("reset_rdata", 32'(rd_a[0]),   32'd0);
    chk("reset_valid", 32'(vld_a[0]),  32'd0);

    // padding bits driven high on every directed frame
    txq0.push_back({1'b1, 16'hA55A, 16'h1234});
    txq0.push_back({1'b1, 16'hA55A, 16'h1234});
    txq0.push_back({1'b1, 16'h8000, 16'h7FFF});
    txq0.push_back({1'b1, 16'h1111, 16'h2222});
    for (int i = 0; i < 80; i++)
      txq1.push_back({1'($urandom), 16'($urandom), 16'($urandom)});
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    en_a[0]  = 1'b1; en_a[1]  = 1'b1;

    wait_valid(0, 600, n);
    chk("first_valid_latency", n, LAT0);
    chk("f1_ldata", 32'(ld_a[0]), 32'hA55A);
    chk("f1_rdata", 32'(rd_a[0]), 32'h1234);
    wait_edge(0, 1'b1, 1, 100, n);
    wait_edge(0, 1'b1, 1, 100, n);
    chk("bclk_period", n, 2 * H0);
    wait_edge(1, 1'b1, 1, 1200, n);
    wait_edge(1, 1'b1, 1, 1200, n);
    chk("lrck_period", n, 128 * H0);

    wait_nval(0, 3, 2000);
    chk("pad_ldata", 32'(ld_a[0]), 32'h8000);
    chk("pad_rdata", 32'(rd_a[0]), 32'h7FFF);
    wait_nval(0, 4, 2000);
    chk("f4_ldata", 32'(ld_a[0]), 32'h1111);
    chk("f4_rdata", 32'(rd_a[0]), 32'h2222);

    // drop enable at left position 8 of the following frame
    wait_edge(1, 1'b0, 1, 1200, n);
    wait_edge(0, 1'b0, 8, 200, n);
    en_a[0] = 1'b0;
    @(negedge clk);
    chk("dis_bclk",  32'(bclk_a[0]), 32'd0);
    chk("dis_lrck",  32'(lrck_a[0]), 32'd0);
    chk("dis_valid", 32'(vld_a[0]),  32'd0);
    nv = nval[0];
    repeat (100) @(negedge clk);
    chk("dis_no_valid", nval[0], nv);
    chk("dis_ldata_held", 32'(ld_a[0]), 32'h1111);
    chk("dis_rdata_held", 32'(rd_a[0]), 32'h2222);
    txq0.push_back({1'b1, 16'h0F0F, 16'hF0F0});
    en_a[0] = 1'b1;
    wait_valid(0, 600, n);
    chk("reen_latency", n, LAT0);
    chk("reen_ldata", 32'(ld_a[0]), 32'h0F0F);
    chk("reen_rdata", 32'(rd_a[0]), 32'hF0F0);

    // reset during right position 10 of the next frame
    txq0.push_back({1'b1, 16'h5555, 16'hAAAA});
    txq0.push_back({1'b1, 16'h1357, 16'h2468});
    wait_edge(1, 1'b1, 1, 1200, n);
    wait_edge(0, 1'b0, 10, 200, n);
    rst_a[0] = 1'b1;
    @(negedge clk);
    chk("rst_bclk",  32'(bclk_a[0]), 32'd0);
    chk("rst_lrck",  32'(lrck_a[0]), 32'd0);
    chk("rst_ldata", 32'(ld_a[0]),   32'd0);
    chk("rst_rdata", 32'(rd_a[0]),   32'd0);
    chk("rst_valid", 32'(vld_a[0]),  32'd0);
    repeat (2) @(negedge clk);
    rst_a[0] = 1'b0;
    wait_valid(0, 600, n);
    chk("rst_release_latency", n, LAT0);
    chk("rst_release_ldata", 32'(ld_a[0]), 32'h1357);
    chk("rst_release_rdata", 32'(rd_a[0]), 32'h2468);

    wait_nval(1, 80, 40000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
